// File: rtl/pc_next_unit.sv
// Program counter with PC+4 / branch / jump / jr selection and a BOOT-FETCH-EXEC-FAULT sequencer.
// Two cycles per instruction minimum; waits in FETCH for ImemReady and in EXEC while Stall is high.
module pc_next_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Offset32,
   input  logic [25:0] JAddr26,
   input  logic [31:0] RegAddr32,
   input  logic        Branch,
   input  logic        BranchNe,
   input  logic        Zero,
   input  logic        Jump,
   input  logic        JumpReg,
   input  logic        Stall,
   input  logic        ImemReady,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        ImemReq,
   output logic        Redirect,
   output logic        Fault,
   output logic [31:0] InstrCount
);

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_FAULT} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] cnt_q;
   logic        req_q;
   logic        redir_q;
   logic        fault_q;

   logic [31:0] pc_d;
   logic        redir_d;
   logic        taken;
   logic        jr_bad;

   assign PCPlus4 = pc_q + 32'd4;
   assign taken   = (Branch & Zero) | (BranchNe & ~Zero);
   assign jr_bad  = JumpReg & (RegAddr32[1:0] != 2'b00);

   // Redirect follows the selected source, so a taken branch to PC+4 still redirects.
   always_comb begin
      pc_d    = PCPlus4;
      redir_d = 1'b0;
      if (JumpReg) begin
         pc_d    = RegAddr32;
         redir_d = 1'b1;
      end else if (Jump) begin
         pc_d    = {PCPlus4[31:28], JAddr26, 2'b00};
         redir_d = 1'b1;
      end else if (taken) begin
         pc_d    = PCPlus4 + Offset32;
         redir_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
         cnt_q   <= 32'd0;
         req_q   <= 1'b0;
         redir_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         redir_q <= 1'b0;
         case (state_q)
            S_BOOT: begin
               state_q <= S_FETCH;
               req_q   <= 1'b1;
            end
            S_FETCH: begin
               if (ImemReady) begin
                  state_q <= S_EXEC;
                  req_q   <= 1'b0;
               end
            end
            S_EXEC: begin
               if (!Stall) begin
                  if (jr_bad) begin
                     fault_q <= 1'b1;
                     state_q <= S_FAULT;
                  end else begin
                     pc_q    <= pc_d;
                     cnt_q   <= cnt_q + 32'd1;
                     redir_q <= redir_d;
                     req_q   <= 1'b1;
                     state_q <= S_FETCH;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign PC         = pc_q;
   assign ImemReq    = req_q;
   assign Redirect   = redir_q;
   assign Fault      = fault_q;
   assign InstrCount = cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: instruction-level model checked every cycle plus directed literal checks.
module tb_pc_next_unit;

   localparam int P_BOOT  = 0;
   localparam int P_FETCH = 1;
   localparam int P_EXEC  = 2;
   localparam int P_FAULT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Offset32, RegAddr32;
   logic [25:0] JAddr26;
   logic        Branch, BranchNe, Zero, Jump, JumpReg, Stall, ImemReady;
   logic [31:0] PC, PCPlus4, InstrCount;
   logic        ImemReq, Redirect, Fault;
   logic [31:0] PC2, PCPlus4_2, InstrCount2;
   logic        ImemReq2, Redirect2, Fault2;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .Offset32(Offset32), .JAddr26(JAddr26),
      .RegAddr32(RegAddr32), .Branch(Branch), .BranchNe(BranchNe), .Zero(Zero),
      .Jump(Jump), .JumpReg(JumpReg), .Stall(Stall), .ImemReady(ImemReady),
      .PC(PC), .PCPlus4(PCPlus4), .ImemReq(ImemReq), .Redirect(Redirect),
      .Fault(Fault), .InstrCount(InstrCount)
   );

   pc_next_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset(reset), .Offset32(Offset32), .JAddr26(JAddr26),
      .RegAddr32(RegAddr32), .Branch(Branch), .BranchNe(BranchNe), .Zero(Zero),
      .Jump(Jump), .JumpReg(JumpReg), .Stall(Stall), .ImemReady(ImemReady),
      .PC(PC2), .PCPlus4(PCPlus4_2), .ImemReq(ImemReq2), .Redirect(Redirect2),
      .Fault(Fault2), .InstrCount(InstrCount2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level view: where the next instruction comes from and whether it is non-sequential.
   function automatic logic [32:0] model_next(input logic [31:0] pc, ra, off,
                                              input logic [25:0] ja,
                                              input logic jr, j, br, bne, z);
      logic [31:0] seq;
      seq = pc + 32'd4;
      if (jr) return {1'b1, ra};
      if (j) return {1'b1, (seq & 32'hF000_0000) | (32'(ja) * 32'd4)};
      if ((br && z) || (bne && !z)) return {1'b1, seq + off};
      return {1'b0, seq};
   endfunction

   int          m_phase = P_BOOT;
   logic        m_valid = 1'b0;
   logic [31:0] m_pc, m_cnt;
   logic        m_redir, m_fault;
   logic [32:0] m_nx;

   assign m_nx = model_next(m_pc, RegAddr32, Offset32, JAddr26, JumpReg, Jump, Branch, BranchNe, Zero);

   always @(posedge clk) begin
      if (reset) begin
         m_valid <= 1'b1;
         m_phase <= P_BOOT;
         m_pc    <= 32'h0;
         m_cnt   <= 32'h0;
         m_redir <= 1'b0;
         m_fault <= 1'b0;
      end else if (m_valid) begin
         m_redir <= 1'b0;
         if (m_phase == P_BOOT) m_phase <= P_FETCH;
         else if (m_phase == P_FETCH && ImemReady) m_phase <= P_EXEC;
         else if (m_phase == P_EXEC && !Stall) begin
            if (JumpReg && (RegAddr32 % 32'd4) != 32'd0) begin
               m_fault <= 1'b1;
               m_phase <= P_FAULT;
            end else begin
               m_pc    <= m_nx[31:0];
               m_redir <= m_nx[32];
               m_cnt   <= m_cnt + 32'd1;
               m_phase <= P_FETCH;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("pc", PC, m_pc);
         chk("pc_plus4", PCPlus4, m_pc + 32'd4);
         chk("imem_req", 32'(ImemReq), 32'(m_phase == P_FETCH));
         chk("redirect", 32'(Redirect), 32'(m_redir));
         chk("fault", 32'(Fault), 32'(m_fault));
         chk("instr_count", InstrCount, m_cnt);
      end
   end

   task automatic clear_ctl();
      Branch = 0; BranchNe = 0; Zero = 0; Jump = 0; JumpReg = 0;
      Offset32 = 32'h0; RegAddr32 = 32'h0; JAddr26 = 26'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Waits for an EXEC cycle, presents one decoded instruction, returns in the following cycle.
   task automatic do_exec(input logic jr, j, br, bne, z,
                          input logic [31:0] ra, off, input logic [25:0] ja);
      int i = 0;
      while (m_phase != P_EXEC && i < 20) begin
         @(negedge clk);
         i++;
      end
      if (m_phase != P_EXEC) begin
         n_checks++;
         n_err++;
         $display("FAIL exec_wait: phase %0d after 20 cycles, required %0d", m_phase, P_EXEC);
      end
      JumpReg = jr; Jump = j; Branch = br; BranchNe = bne; Zero = z;
      RegAddr32 = ra; Offset32 = off; JAddr26 = ja;
      @(negedge clk);
      clear_ctl();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int reqs;
      reset = 1'b1;
      Stall = 1'b0;
      ImemReady = 1'b1;
      clear_ctl();
      do_reset();
      chk("rst_pc", PC, 32'h0);
      chk("rst_pc4", PCPlus4, 32'h4);
      chk("rst_req", 32'(ImemReq), 32'h0);
      chk("rst_count", InstrCount, 32'h0);
      chk("rst_wrap_pc4", PCPlus4_2, 32'h0);

      // Sequential flow; the wrap instance shares the stimulus.
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) chk("seq_first_req", 32'(ImemReq), 32'h1);
         if (k == 2) chk("seq_pc_c2", PC, 32'h0);
         if (k == 2) chk("wrap_pc_c2", PC2, 32'hFFFF_FFFC);
         if (k == 3) chk("wrap_pc_c3", PC2, 32'h0);
         if (k == 3) chk("wrap_no_redirect", 32'(Redirect2), 32'h0);
         if (k == 4) chk("seq_pc_c4", PC, 32'h4);
         if (k == 6) chk("seq_pc_c6", PC, 32'h8);
         if (k == 7) chk("seq_count3", InstrCount, 32'h3);
      end

      do_exec(0, 1, 0, 0, 0, 32'h0, 32'h0, 26'h40);
      chk("jump_to_100", PC, 32'h100);
      do_exec(0, 0, 1, 0, 1, 32'h0, 32'hFFFF_FFF0, 26'h0);
      chk("beq_taken_pc", PC, 32'hF4);
      chk("beq_taken_redirect", 32'(Redirect), 32'h1);
      do_exec(0, 1, 0, 0, 0, 32'h0, 32'h0, 26'h40);
      do_exec(0, 0, 1, 0, 0, 32'h0, 32'hFFFF_FFF0, 26'h0);
      chk("beq_not_taken_pc", PC, 32'h104);
      chk("beq_not_taken_redirect", 32'(Redirect), 32'h0);
      do_exec(0, 1, 0, 0, 0, 32'h0, 32'h0, 26'h40);
      do_exec(0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFF0, 26'h0);
      chk("bne_taken_pc", PC, 32'hF4);

      do_exec(1, 0, 0, 0, 0, 32'h3000_0010, 32'h0, 26'h0);
      do_exec(1, 1, 1, 0, 1, 32'h0000_4000, 32'h0, 26'h40);
      chk("jr_priority_pc", PC, 32'h4000);
      do_exec(1, 0, 0, 0, 0, 32'h3000_0010, 32'h0, 26'h0);
      do_exec(0, 1, 0, 0, 0, 32'h0, 32'h0, 26'h40);
      chk("jump_region_pc", PC, 32'h3000_0100);
      do_exec(1, 0, 0, 0, 0, 32'h3000_0010, 32'h0, 26'h0);

      do_exec(1, 0, 0, 0, 0, 32'h0000_4002, 32'h0, 26'h0);
      chk("misaligned_fault", 32'(Fault), 32'h1);
      reqs = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ImemReq) reqs++;
      end
      chk("fault_req_cycles", reqs, 0);
      chk("fault_pc_hold", PC, 32'h3000_0010);
      chk("fault_count_hold", InstrCount, 32'd14);
      do_reset();
      chk("fault_reset_pc", PC, 32'h0);
      chk("fault_reset_flag", 32'(Fault), 32'h0);

      // ImemReady low for three FETCH cycles; Stall held from BOOT through two EXEC cycles.
      ImemReady = 1'b0;
      Stall = 1'b1;
      do_reset();
      reqs = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k <= 5 && ImemReq) reqs++;
         if (k == 4) ImemReady = 1'b1;
         if (k == 6 || k == 7) begin
            chk("stall_pc", PC, 32'h0);
            chk("stall_count", InstrCount, 32'h0);
         end
         if (k == 7) Stall = 1'b0;
         if (k == 8) begin
            chk("handshake_req_cycles", reqs, 4);
            chk("after_stall_pc", PC, 32'h4);
            chk("after_stall_count", InstrCount, 32'h1);
            chk("after_stall_req", 32'(ImemReq), 32'h1);
         end
      end

      reset = 1'b1;
      @(negedge clk);
      chk("mid_fetch_reset_req", 32'(ImemReq), 32'h0);
      chk("mid_fetch_reset_pc", PC, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("boot_to_fetch_req", 32'(ImemReq), 32'h1);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
